// File: rtl/player_hit_tracker_pkg.sv
// Shared definitions for the player hit tracker: slot geometry of the packed
// enemy-projectile buses, FSM state encoding and slot field extractors.
package player_hit_tracker_pkg;

  localparam int NUM_ENEMY_SLOTS = 5;
  localparam int SLOT_Y_W        = 9;
  localparam int SLOT_X_W        = 9;   // slots 0..3
  localparam int SLOT4_X_W       = 10;  // last slot has one extra x bit
  localparam int SLOT4_X_LSB     = 36;
  localparam int PROJ_X_BUS_W    = 46;
  localparam int PROJ_Y_BUS_W    = 45;
  localparam int COORD_W         = 10;
  localparam int IDX_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  // x of slot idx, zero-extended to COORD_W; slot 4 carries a full 10-bit x
  function automatic logic [COORD_W-1:0] slot_x(input logic [PROJ_X_BUS_W-1:0] bus,
                                                input logic [IDX_W-1:0]        idx);
    logic [COORD_W-1:0] r;
    r = '0;
    if (idx == IDX_W'(NUM_ENEMY_SLOTS-1))
      r = bus[SLOT4_X_LSB +: SLOT4_X_W];
    else if (idx < IDX_W'(NUM_ENEMY_SLOTS-1))
      r = {1'b0, bus[int'(idx)*SLOT_X_W +: SLOT_X_W]};
    return r;
  endfunction

  function automatic logic [SLOT_Y_W-1:0] slot_y(input logic [PROJ_Y_BUS_W-1:0] bus,
                                                 input logic [IDX_W-1:0]        idx);
    logic [SLOT_Y_W-1:0] r;
    r = '0;
    if (idx < IDX_W'(NUM_ENEMY_SLOTS))
      r = bus[int'(idx)*SLOT_Y_W +: SLOT_Y_W];
    return r;
  endfunction

endpackage

// File: rtl/player_hit_tracker_overlap.sv
// proj_box_overlap: combinational point-in-box test of one projectile against
// the player ship box, widened by PROJ_HW on both x sides.
// Ports: proj_x_i/proj_y_i projectile point (y==0 = inactive slot),
//        box_x_i/box_y_i ship box top-left corner, hit_o overlap result.
module proj_box_overlap
  import player_hit_tracker_pkg::*;
#(
  parameter int PLAYER_W = 20,
  parameter int PLAYER_H = 10,
  parameter int PROJ_HW  = 2
) (
  input  logic [COORD_W-1:0]  proj_x_i,
  input  logic [SLOT_Y_W-1:0] proj_y_i,
  input  logic [COORD_W-1:0]  box_x_i,
  input  logic [COORD_W-1:0]  box_y_i,
  output logic                hit_o
);

  // 11-bit arithmetic: box edge + size never wraps
  logic [10:0] px, py, bx, by;

  assign px = {1'b0, proj_x_i};
  assign py = {2'b0, proj_y_i};
  assign bx = {1'b0, box_x_i};
  assign by = {1'b0, box_y_i};

  // x side compared as px+HW >= bx so a box at x=0 still catches x=0
  assign hit_o = (proj_y_i != '0) &&
                 (py >= by) && (py < by + 11'(PLAYER_H)) &&
                 (px + 11'(PROJ_HW) >= bx) && (px < bx + 11'(PLAYER_W + PROJ_HW));

endmodule

// File: rtl/player_hit_tracker.sv
// player_hit_tracker: each game tick, scans the 5 enemy projectile slots one
// per cycle against the player box, debits one life per scan with any hit,
// then holds an invulnerability window. game_over is sticky until clr/play=0.
// Ports: dclk clock, clr sync active-high reset, tick game-step strobe,
//        play enable (0 = idle, lives reloaded), enemy_proj_x/y packed slots,
//        player_x/y box corner; lives, player_hit pulse, hit_mask of last
//        scan, invuln, game_over, busy (SCAN/RESOLVE).
module player_hit_tracker
  import player_hit_tracker_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_W      = 3,
  parameter int PLAYER_W     = 20,
  parameter int PLAYER_H     = 10,
  parameter int PROJ_HW      = 2,
  parameter int INVULN_TICKS = 60
) (
  input  logic                       dclk,
  input  logic                       clr,
  input  logic                       tick,
  input  logic                       play,
  input  logic [PROJ_X_BUS_W-1:0]    enemy_proj_x,
  input  logic [PROJ_Y_BUS_W-1:0]    enemy_proj_y,
  input  logic [COORD_W-1:0]         player_x,
  input  logic [COORD_W-1:0]         player_y,
  output logic [LIVES_W-1:0]         lives,
  output logic                       player_hit,
  output logic [NUM_ENEMY_SLOTS-1:0] hit_mask,
  output logic                       invuln,
  output logic                       game_over,
  output logic                       busy
);

  localparam int CNT_W = (INVULN_TICKS < 1) ? 1 : $clog2(INVULN_TICKS + 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_ENEMY_SLOTS-1:0] acc_q, acc_d;
  logic [NUM_ENEMY_SLOTS-1:0] mask_q, mask_d;
  logic [LIVES_W-1:0]         lives_q, lives_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       go_q, go_d;
  logic                       hit_q, hit_d;
  logic                       ov;

  // single comparator shared across slots, selected by the scan index
  proj_box_overlap #(
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H),
    .PROJ_HW  (PROJ_HW)
  ) u_overlap (
    .proj_x_i (slot_x(enemy_proj_x, idx_q)),
    .proj_y_i (slot_y(enemy_proj_y, idx_q)),
    .box_x_i  (player_x),
    .box_y_i  (player_y),
    .hit_o    (ov)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    go_d    = go_q;
    hit_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick && play && !go_q) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_SCAN: begin
        acc_d[idx_q] = ov;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_ENEMY_SLOTS-1)) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        mask_d  = acc_q;
        state_d = ST_IDLE;
        // an active window only counts down; hits inside it are ignored
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (acc_q != '0) begin
          cnt_d = CNT_W'(INVULN_TICKS);
          hit_d = 1'b1;
          if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
          if (lives_q <= LIVES_W'(1)) go_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // play low behaves exactly like clr, aborting any scan in flight
  always_ff @(posedge dclk) begin
    if (clr || !play) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      lives_q <= LIVES_W'(LIVES_INIT);
      cnt_q   <= '0;
      go_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      hit_q   <= hit_d;
    end
  end

  assign lives      = lives_q;
  assign player_hit = hit_q;
  assign hit_mask   = mask_q;
  assign invuln     = (cnt_q != '0);
  assign game_over  = go_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_hit_tracker.sv
// Directed bench for player_hit_tracker: reset, aborts, single/multi hit,
// invulnerability spacing, box boundaries and game over.
module tb_player_hit_tracker;

  logic        dclk = 1'b0;
  logic        clr, tick, play;
  logic [45:0] ex;
  logic [44:0] ey;
  logic [9:0]  pxp, pyp;
  logic [2:0]  lives;
  logic        player_hit, invuln, game_over, busy;
  logic [4:0]  hit_mask;

  int checks = 0;
  int errors = 0;

  always #5 dclk = ~dclk;

  player_hit_tracker dut (
    .dclk(dclk), .clr(clr), .tick(tick), .play(play),
    .enemy_proj_x(ex), .enemy_proj_y(ey), .player_x(pxp), .player_y(pyp),
    .lives(lives), .player_hit(player_hit), .hit_mask(hit_mask),
    .invuln(invuln), .game_over(game_over), .busy(busy)
  );

  task automatic step();
    @(posedge dclk); #1;
  endtask

  task automatic clear_slots();
    ex = '0; ey = '0;
  endtask

  task automatic set_slot(input int i, input int x, input int y);
    logic [9:0] xv;
    logic [8:0] yv;
    xv = x[9:0]; yv = y[8:0];
    if (i == 4) ex[45:36] = xv;
    else        ex[9*i +: 9] = xv[8:0];
    ey[9*i +: 9] = yv;
  endtask

  task automatic do_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  // Pulses tick for one cycle then watches 9 further edges.
  // hit_at = edge index (after the tick-sampling edge) of first player_hit.
  task automatic run_tick(output int hit_at, output int hits, output logic busy1);
    tick = 1'b1; step(); tick = 1'b0;
    busy1 = busy; hit_at = -1; hits = 0;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (player_hit) begin
        hits++;
        if (hit_at < 0) hit_at = e;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; play = 1'b0; tick = 1'b0; clear_slots(); pxp = '0; pyp = '0;
    step(); step();
    checks++; if (lives !== 3'd3)     begin errors++; $display("FAIL reset_lives got %0d exp 3", lives); end
    checks++; if (player_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", player_hit); end
    checks++; if (hit_mask !== 5'b0)  begin errors++; $display("FAIL reset_mask got %b exp 0", hit_mask); end
    checks++; if (invuln !== 1'b0)    begin errors++; $display("FAIL reset_invuln got %b exp 0", invuln); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_go got %b exp 0", game_over); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    clr = 1'b0; play = 1'b1;
  endtask

  // abort by clr (sel=0) or by play falling (sel=1) with slot 2 overlapping
  task automatic test_abort(input int sel);
    int seen;
    do_clr(); clear_slots(); pxp = 10'd200; pyp = 10'd400; set_slot(2, 205, 402);
    tick = 1'b1; step(); tick = 1'b0; step(); step();
    if (sel == 0) clr = 1'b1; else play = 1'b0;
    step();
    clr = 1'b0; play = 1'b1;
    checks++; if (lives !== 3'd3)    begin errors++; $display("FAIL abort%0d_lives got %0d exp 3", sel, lives); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort%0d_busy got %b exp 0", sel, busy); end
    checks++; if (hit_mask !== 5'b0) begin errors++; $display("FAIL abort%0d_mask got %b exp 0", sel, hit_mask); end
    seen = 0;
    for (int e = 0; e < 8; e++) begin
      step();
      if (player_hit) seen++;
    end
    checks++; if (seen != 0 || lives !== 3'd3)
      begin errors++; $display("FAIL abort%0d_nodebit got hits=%0d lives=%0d exp 0/3", sel, seen, lives); end
  endtask

  task automatic test_single_hit();
    int at, n; logic b1;
    do_clr(); clear_slots(); pxp = 10'd200; pyp = 10'd400; set_slot(1, 205, 402);
    run_tick(at, n, b1);
    checks++; if (b1 !== 1'b1)       begin errors++; $display("FAIL single_busy got %b exp 1", b1); end
    checks++; if (at != 6 || n != 1) begin errors++; $display("FAIL single_latency got edge %0d count %0d exp 6/1", at, n); end
    checks++; if (lives !== 3'd2)    begin errors++; $display("FAIL single_lives got %0d exp 2", lives); end
    checks++; if (hit_mask !== 5'b00010) begin errors++; $display("FAIL single_mask got %b exp 00010", hit_mask); end
    checks++; if (invuln !== 1'b1)   begin errors++; $display("FAIL single_invuln got %b exp 1", invuln); end
  endtask

  task automatic test_multi_hit();
    int at, n; logic b1;
    do_clr(); clear_slots(); pxp = 10'd200; pyp = 10'd400;
    set_slot(0, 210, 405); set_slot(3, 200, 400); set_slot(4, 219, 409);
    set_slot(1, 300, 405); set_slot(2, 210, 420);
    run_tick(at, n, b1);
    checks++; if (hit_mask !== 5'b11001) begin errors++; $display("FAIL multi_mask got %b exp 11001", hit_mask); end
    checks++; if (n != 1)          begin errors++; $display("FAIL multi_pulses got %0d exp 1", n); end
    checks++; if (lives !== 3'd2)  begin errors++; $display("FAIL multi_lives got %0d exp 2", lives); end
  endtask

  task automatic test_invuln();
    int at, n, first, second, cnt; logic b1;
    do_clr(); clear_slots(); pxp = 10'd200; pyp = 10'd400; set_slot(0, 205, 402);
    first = -1; second = -1; cnt = 0;
    for (int t = 0; t < 62; t++) begin
      run_tick(at, n, b1);
      if (n > 0) begin
        cnt++;
        if (first < 0) first = t; else if (second < 0) second = t;
      end
    end
    checks++; if (cnt != 2) begin errors++; $display("FAIL invuln_debits got %0d exp 2", cnt); end
    checks++; if (second - first - 1 != 60)
      begin errors++; $display("FAIL invuln_gap got %0d exp 60", second - first - 1); end
    checks++; if (lives !== 3'd1) begin errors++; $display("FAIL invuln_lives got %0d exp 1", lives); end
  endtask

  task automatic test_boundaries();
    int bpx [10] = '{  0, 200, 200, 200, 200, 200, 200, 200, 200, 600};
    int bpy [10] = '{400, 400, 400, 400, 400, 400,   0, 400, 400, 400};
    int bsl [10] = '{  0,   0,   1,   2,   3,   0,   1,   2,   3,   4};
    int bx  [10] = '{  0, 178, 222, 221, 205, 205, 205, 198, 197, 619};
    int by  [10] = '{405, 405, 405, 405, 410, 409,   0, 400, 400, 409};
    int bex [10] = '{  1,   0,   0,   1,   0,   1,   0,   1,   0,   1};
    int at, n; logic b1;
    logic [4:0] em;
    logic [2:0] el;
    for (int k = 0; k < 10; k++) begin
      do_clr(); clear_slots();
      pxp = bpx[k][9:0]; pyp = bpy[k][9:0];
      set_slot(bsl[k], bx[k], by[k]);
      run_tick(at, n, b1);
      em = (bex[k] != 0) ? (5'b1 << bsl[k]) : 5'b0;
      el = (bex[k] != 0) ? 3'd2 : 3'd3;
      checks++; if (hit_mask !== em)
        begin errors++; $display("FAIL bound%0d_mask got %b exp %b", k, hit_mask, em); end
      checks++; if (lives !== el)
        begin errors++; $display("FAIL bound%0d_lives got %0d exp %0d", k, lives, el); end
    end
  endtask

  task automatic test_game_over();
    int at, n, hits, t; logic b1;
    do_clr(); clear_slots(); pxp = 10'd200; pyp = 10'd400; set_slot(0, 205, 402);
    hits = 0; t = 0;
    while (!game_over && t < 200) begin
      run_tick(at, n, b1);
      hits += n; t++;
    end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_flag got %b exp 1", game_over); end
    checks++; if (lives !== 3'd0)     begin errors++; $display("FAIL go_lives got %0d exp 0", lives); end
    checks++; if (hits != 3)          begin errors++; $display("FAIL go_hits got %0d exp 3", hits); end
    checks++; if (t != 123)           begin errors++; $display("FAIL go_ticks got %0d exp 123", t); end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL go_blocks_scan busy got %b exp 0", busy); end
    step();
    play = 1'b0; step(); play = 1'b1; step();
    checks++; if (lives !== 3'd3)     begin errors++; $display("FAIL go_reload_lives got %0d exp 3", lives); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL go_reload_flag got %b exp 0", game_over); end
  endtask

  initial begin
    test_reset();
    test_abort(0);
    test_abort(1);
    test_single_hit();
    test_multi_hit();
    test_invuln();
    test_boundaries();
    test_game_over();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
